// File: rtl/uart_receiver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_receiver_pkg                                             |
// | Purpose  : Shared definitions for the UART receive path: parity mode     |
// |            codes, receiver state encoding, data-bit mask and parity      |
// |            helpers.                                                      |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package uart_receiver_pkg;

  // Parity mode codes (shared with the transmitter)
  localparam logic [1:0] PARITY_SPACE = 2'b00;
  localparam logic [1:0] PARITY_ODD   = 2'b01;
  localparam logic [1:0] PARITY_EVEN  = 2'b10;
  localparam logic [1:0] PARITY_MARK  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PAR       = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Mask of valid data bits for a frame of (data_bits + 5) bits.
  function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
    return 8'hFF >> (2'd3 - data_bits);
  endfunction

  // Expected parity bit for already-masked data.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    logic p;
    case (mode)
      PARITY_SPACE: p = 1'b0;
      PARITY_MARK:  p = 1'b1;
      PARITY_EVEN:  p = ^data;
      default:      p = ~^data;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_receiver_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_receiver_sync                                            |
// | Purpose  : Multi-stage synchronizer for the asynchronous rx line plus a  |
// |            registered falling-edge detector.                             |
// | Ports    : clk, rst_n      clock / async active-low reset                |
// |            rx             raw serial input (idle high)                  |
// |            rxSync         synchronized rx                               |
// |            rxFall         one-cycle pulse on synchronized 1->0          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_receiver_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rxSync,
  output logic rxFall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync_d;

  // Flops reset to the idle level so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= '1;
      sync_d <= 1'b1;
      rxFall <= 1'b0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], rx};
      sync_d <= chain[SYNC_STAGES-1];
      rxFall <= sync_d & ~chain[SYNC_STAGES-1];
    end
  end

  assign rxSync = chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_receiver                                                 |
// | Purpose  : UART receive path. Recovers start / 5-8 data bits (LSB first) |
// |            / optional parity / stop frames and presents them over a     |
// |            valid/ack handshake with parity, framing and overrun flags.  |
// | Ports    : clk, rst_n         clock / async active-low reset            |
// |            rx                 serial line, idle high                    |
// |            dataBits           data bits = dataBits+5                    |
// |            hasParity          parity bit present                        |
// |            parityMode         00 space, 11 mark, 10 even, 01 odd        |
// |            clockDivisor       bit period = 2*clockDivisor+2 clk         |
// |            rxData/rxValid     received frame and its valid flag         |
// |            rxAck              consumer accepts the frame                |
// |            parityError, framingError, overrun, busy   status            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLOCK_DIVISOR_WIDTH = 24,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rx,
  input  logic [1:0]                     dataBits,
  input  logic                           hasParity,
  input  logic [1:0]                     parityMode,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  output logic [7:0]                     rxData,
  output logic                           rxValid,
  input  logic                           rxAck,
  output logic                           parityError,
  output logic                           framingError,
  output logic                           overrun,
  output logic                           busy
);

  localparam int CW = CLOCK_DIVISOR_WIDTH;

  rx_state_t   state, state_next;
  logic        rx_sync, rx_fall;

  // Frame configuration captured on the start edge
  logic [CW-1:0] div_q;
  logic [1:0]    bits_q;
  logic          has_par_q;
  logic [1:0]    pmode_q;

  logic [CW:0]   cnt;
  logic [CW:0]   sample_point;
  logic          sample;
  logic          last_bit;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_err_q, frm_err_q, frame_done;

  uart_receiver_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .rxSync (rx_sync),
    .rxFall (rx_fall)
  );

  // The start sample lands mid-bit (div), every later one a full bit on
  // (2*div+1, built by appending a 1 so it cannot overflow).
  always_comb begin
    sample_point = (state == ST_START) ? {1'b0, div_q} : {div_q, 1'b1};
    sample       = (state == ST_START || state == ST_DATA ||
                    state == ST_PAR   || state == ST_STOP) && (cnt == sample_point);
    // Last data bit index is dataBits+4, i.e. {1, dataBits}
    last_bit     = (bit_idx == {1'b1, bits_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (rx_fall) state_next = ST_START;
      ST_START:     if (sample) state_next = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:      if (sample && last_bit) state_next = has_par_q ? ST_PAR : ST_STOP;
      ST_PAR:       if (sample) state_next = ST_STOP;
      ST_STOP:      if (sample) state_next = rx_sync ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rx_sync) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Bit timing, deserializer and per-frame error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      bits_q     <= '0;
      has_par_q  <= 1'b0;
      pmode_q    <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (rx_fall) begin
          div_q     <= clockDivisor;
          bits_q    <= dataBits;
          has_par_q <= hasParity;
          pmode_q   <= parityMode;
          cnt       <= '0;
          bit_idx   <= '0;
          shreg     <= '0;
          par_err_q <= 1'b0;
          frm_err_q <= 1'b0;
        end
      end else if (state != ST_WAIT_HIGH) begin
        cnt <= sample ? '0 : cnt + 1'b1;
      end

      if (sample) begin
        case (state)
          ST_DATA: begin
            shreg[bit_idx] <= rx_sync;
            bit_idx        <= bit_idx + 3'd1;
          end
          ST_PAR:  par_err_q <= (rx_sync != parity_bit(shreg & data_mask(bits_q), pmode_q));
          ST_STOP: begin
            frm_err_q  <= ~rx_sync;
            frame_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Output registers and handshake. A completing frame takes priority over
  // a plain ack; an ack in the completion cycle frees the slot for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxData       <= '0;
      rxValid      <= 1'b0;
      parityError  <= 1'b0;
      framingError <= 1'b0;
      overrun      <= 1'b0;
    end else if (frame_done) begin
      if (!rxValid || rxAck) begin
        rxData       <= shreg & data_mask(bits_q);
        parityError  <= par_err_q;
        framingError <= frm_err_q;
        rxValid      <= 1'b1;
        overrun      <= 1'b0;
      end else begin
        overrun      <= 1'b1;
      end
    end else if (rxAck && rxValid) begin
      rxValid <= 1'b0;
      overrun <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire
